// File: rtl/lane_speed_meter_pkg.sv
// Shared types and constants for the lane speed meter: FSM encoding, divider width,
// cm-per-ms to 0.1 km/h scale factor and the ms tick divisor helper.
package lane_speed_meter_pkg;

  typedef enum logic [0:0] {StIdle, StTiming} meter_state_e;

  // 1 cm/ms = 36 km/h = 360 units of 0.1 km/h
  localparam int unsigned CM_TO_KMH10 = 360;
  localparam int unsigned DIV_W       = 32;

  function automatic int unsigned ms_tick_div(input int unsigned sys_freq);
    return (sys_freq < 1000) ? 1 : sys_freq / 1000;
  endfunction

endpackage

// File: rtl/lane_speed_meter_seq_divider.sv
// Restoring divider, one quotient bit per clock. Operands load on start when idle; done
// pulses for one clock after the last bit, with div_zero flagging a zero divisor.
module lane_speed_meter_seq_divider
  import lane_speed_meter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [DIV_W-1:0] quotient
);

  localparam int unsigned CntW = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] quo_q;
  logic [DIV_W-1:0] dsr_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic [DIV_W:0]   rem_shift;
  logic [DIV_W-1:0] rem_diff;
  logic             fits;

  // Remainder stays below the divisor, so the difference always fits in DIV_W bits
  always_comb begin
    rem_shift = {rem_q, quo_q[DIV_W-1]};
    fits      = rem_shift >= {1'b0, dsr_q};
    rem_diff  = rem_shift[DIV_W-1:0] - dsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        rem_q  <= '0;
        quo_q  <= dividend;
        dsr_q  <= divisor;
        zero_q <= (divisor == '0);
        cnt_q  <= CntW'(DIV_W);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= fits ? rem_diff : rem_shift[DIV_W-1:0];
        quo_q <= {quo_q[DIV_W-2:0], fits};
        cnt_q <= cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = zero_q;
  assign quotient = quo_q;

endmodule

// File: rtl/lane_speed_meter.sv
// N-sensor lane speed meter: times sensor-to-sensor intervals in ms and reports per-segment
// speed in 0.1 km/h over valid/ready. Optional overspeed flag under OVERSPEED_FLAG_EN.
module lane_speed_meter
  import lane_speed_meter_pkg::*;
#(
  parameter int unsigned SYS_FREQ    = 50000000,
  parameter int unsigned N_SENSORS   = 3,
  parameter int unsigned WIDTH_MS    = 12,
  parameter int unsigned WIDTH_SPEED = 14,
  parameter logic [16*(N_SENSORS-1)-1:0] SEG_DIST_CM = {16'd600, 16'd400},
  parameter int unsigned TIMEOUT_MS  = 2000,
`ifdef OVERSPEED_FLAG_EN
  parameter int unsigned SPEED_LIMIT = 600,
`endif
  localparam int unsigned SEG_W = (N_SENSORS > 2) ? $clog2(N_SENSORS - 1) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_SENSORS-1:0]   sensor,
  input  logic                   speed_ready,
`ifdef OVERSPEED_FLAG_EN
  output logic                   overspeed,
`endif
  output logic                   speed_valid,
  output logic [WIDTH_SPEED-1:0] speed,
  output logic [SEG_W-1:0]       seg_idx,
  output logic                   busy,
  output logic                   timeout,
  output logic                   overrun
);

  localparam int unsigned TickDiv = ms_tick_div(SYS_FREQ);
  localparam int unsigned TickW   = $clog2(TickDiv + 1);

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic [N_SENSORS-1:0]   sync1_q, sync2_q, sync3_q, rise_q;
  logic [N_SENSORS-2:0]   rise_hi;
  meter_state_e           state_q;
  logic [SEG_W-1:0]       k_q;
  logic [TickW-1:0]       tick_q;
  logic [WIDTH_MS-1:0]    ms_q, ms_next;
  logic                   tick_wrap, rise_next, last_seg;
  logic                   cap_timing, cap_idle, cap, cap_ok;
  logic [SEG_W-1:0]       cap_seg, seg_pend_q;
  logic [WIDTH_MS-1:0]    cap_ms;
  logic [15:0]            seg_dist;
  logic [DIV_W-1:0]       dividend, divisor, quotient;
  logic                   div_busy, div_done, div_zero;
  logic [WIDTH_SPEED-1:0] sat_speed;
  logic                   timeout_q, overrun_q, valid_q;
  logic [WIDTH_SPEED-1:0] speed_q;
  logic [SEG_W-1:0]       seg_q;

  // Async assert, synchronous release of the internal reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
    end
  end

  always_comb begin
    rise_hi    = rise_q[N_SENSORS-1:1];
    rise_next  = rise_hi[k_q];
    last_seg   = (k_q == SEG_W'(N_SENSORS - 2));
    tick_wrap  = (tick_q == TickW'(TickDiv - 1));
    ms_next    = ms_q;
    if (tick_wrap && ms_q != '1) ms_next = ms_q + WIDTH_MS'(1);
    cap_timing = (state_q == StTiming) && rise_next;
    // Sensors 0 and 1 rising together from idle close segment 0 with a zero interval
    cap_idle   = (state_q == StIdle) && rise_q[0] && rise_q[1];
    cap        = cap_timing || cap_idle;
    cap_ok     = cap && !div_busy && !valid_q;
    cap_seg    = cap_idle ? '0 : k_q;
    cap_ms     = cap_idle ? '0 : ms_next;
    seg_dist   = SEG_DIST_CM[cap_seg*16 +: 16];
    dividend   = DIV_W'(seg_dist) * DIV_W'(CM_TO_KMH10);
    divisor    = DIV_W'(cap_ms);
    sat_speed  = (div_zero || (|quotient[DIV_W-1:WIDTH_SPEED])) ? '1
                                                                 : quotient[WIDTH_SPEED-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      tick_q    <= '0;
      ms_q      <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      overrun_q <= cap && !cap_ok;
      case (state_q)
        StIdle: begin
          k_q    <= '0;
          tick_q <= '0;
          ms_q   <= '0;
          if (rise_q[0]) begin
            state_q <= StTiming;
            if (cap_idle && !last_seg) k_q <= SEG_W'(1);
          end
        end
        StTiming: begin
          if (cap_timing) begin
            tick_q <= '0;
            ms_q   <= '0;
            if (rise_q[0])      k_q <= '0;
            else if (!last_seg) k_q <= k_q + SEG_W'(1);
            else                state_q <= StIdle;
          end else if (rise_q[0]) begin
            k_q    <= '0;
            tick_q <= '0;
            ms_q   <= '0;
          end else if (ms_next == WIDTH_MS'(TIMEOUT_MS)) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            tick_q <= tick_wrap ? '0 : tick_q + TickW'(1);
            ms_q   <= ms_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  lane_speed_meter_seq_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (cap_ok),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (div_busy),
    .done     (div_done),
    .div_zero (div_zero),
    .quotient (quotient)
  );

`ifdef OVERSPEED_FLAG_EN
  logic overspeed_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      speed_q    <= '0;
      seg_q      <= '0;
      seg_pend_q <= '0;
`ifdef OVERSPEED_FLAG_EN
      overspeed_q <= 1'b0;
`endif
    end else begin
      if (cap_ok) seg_pend_q <= cap_seg;
      if (div_done) begin
        valid_q <= 1'b1;
        speed_q <= sat_speed;
        seg_q   <= seg_pend_q;
`ifdef OVERSPEED_FLAG_EN
        overspeed_q <= (sat_speed > WIDTH_SPEED'(SPEED_LIMIT));
`endif
      end else if (valid_q && speed_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef OVERSPEED_FLAG_EN
  assign overspeed = overspeed_q;
`endif
  assign speed_valid = valid_q;
  assign speed       = speed_q;
  assign seg_idx     = seg_q;
  assign busy        = (state_q != StIdle);
  assign timeout     = timeout_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lane_speed_meter.sv
// Directed bench for lane_speed_meter at 5 clk/ms; overspeed cases build with OVERSPEED_FLAG_EN.
module tb_lane_speed_meter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  sensor;
  logic        speed_ready;
  logic        speed_valid;
  logic [13:0] speed;
  logic [0:0]  seg_idx;
  logic        busy;
  logic        timeout;
  logic        overrun;
`ifdef OVERSPEED_FLAG_EN
  logic        overspeed;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;
  int lat;
  int n;
  logic saw_valid;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lane_speed_meter #(
    .SYS_FREQ (5000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor      (sensor),
    .speed_ready (speed_ready),
`ifdef OVERSPEED_FLAG_EN
    .overspeed   (overspeed),
`endif
    .speed_valid (speed_valid),
    .speed       (speed),
    .seg_idx     (seg_idx),
    .busy        (busy),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic raise_at(input int idx, input int target);
    wait_until(target);
    sensor[idx] = 1'b1;
    repeat (4) @(negedge clk);
    sensor[idx] = 1'b0;
  endtask

  // lat counts clock edges from the first edge sampling the sensor rise
  task automatic wait_valid(input int from_cyc, output int lat_o);
    int k = 0;
    while (!speed_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    lat_o = speed_valid ? cyc - (from_cyc + 1) : -1;
    check("valid_seen", {31'd0, speed_valid}, 32'd1);
  endtask

  task automatic accept();
    speed_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_clear", {31'd0, speed_valid}, 32'd0);
    speed_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   {31'd0, speed_valid}, 32'd0);
    check({tag, "_speed"},   {18'd0, speed}, 32'd0);
    check({tag, "_seg"},     {31'd0, seg_idx}, 32'd0);
    check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    sensor      = '0;
    speed_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 400 cm in 640 ms, then 600 cm in 960 ms: both 225
    t0 = cyc + 2;
    raise_at(0, t0);
    check("busy_timing", {31'd0, busy}, 32'd1);
    raise_at(1, t0 + 3200);
    wait_valid(t0 + 3200, lat);
    check("lat_seg0", lat, 32'd36);
    check("speed_seg0", {18'd0, speed}, 32'd225);
    check("seg_seg0", {31'd0, seg_idx}, 32'd0);
    @(posedge clk); #1;
    check("valid_held", {31'd0, speed_valid}, 32'd1);
    accept();
    raise_at(2, t0 + 8000);
    wait_valid(t0 + 8000, lat);
    check("speed_seg1", {18'd0, speed}, 32'd225);
    check("seg_seg1", {31'd0, seg_idx}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    accept();

    // Timeout after 2000 ms with no second sensor
    t0 = cyc + 2;
    raise_at(0, t0);
    saw_valid = 1'b0;
    n = 0;
    while (!timeout && n < 10100) begin
      @(posedge clk); #1;
      n++;
      if (speed_valid) saw_valid = 1'b1;
    end
    check("timeout_at", cyc - (t0 + 1), 32'd10003);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_novalid", {31'd0, saw_valid}, 32'd0);
    @(posedge clk); #1;
    check("timeout_pulse", {31'd0, timeout}, 32'd0);

    // Consumer stalled: segment 1 result must be dropped with an overrun pulse
    t0 = cyc + 2;
    raise_at(0, t0);
    raise_at(1, t0 + 3200);
    raise_at(2, t0 + 8000);
    n = 0;
    while (!overrun && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("overrun_at", cyc - (t0 + 8001), 32'd3);
    check("ovr_valid", {31'd0, speed_valid}, 32'd1);
    check("ovr_speed", {18'd0, speed}, 32'd225);
    check("ovr_seg", {31'd0, seg_idx}, 32'd0);
    @(posedge clk); #1;
    check("overrun_pulse", {31'd0, overrun}, 32'd0);
    accept();
    repeat (40) @(posedge clk);
    #1;
    check("ovr_dropped", {31'd0, speed_valid}, 32'd0);

    // Sensors 0 and 1 together: zero interval saturates
    t0 = cyc + 2;
    wait_until(t0);
    sensor[1:0] = 2'b11;
    repeat (4) @(negedge clk);
    sensor = '0;
    wait_valid(t0, lat);
    check("lat_sat", lat, 32'd36);
    check("speed_sat", {18'd0, speed}, 32'd16383);
    check("seg_sat", {31'd0, seg_idx}, 32'd0);
    check("busy_seg1", {31'd0, busy}, 32'd1);
    accept();

    // Reset while segment 1 is dividing
    raise_at(2, cyc + 2);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_valid", {31'd0, speed_valid}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef OVERSPEED_FLAG_EN
    t0 = cyc + 2;
    raise_at(0, t0);
    raise_at(1, t0 + 1000);
    wait_valid(t0 + 1000, lat);
    check("speed_fast", {18'd0, speed}, 32'd720);
    check("overspeed_fast", {31'd0, overspeed}, 32'd1);
    accept();
    t0 = cyc + 2;
    raise_at(0, t0);
    raise_at(1, t0 + 3200);
    wait_valid(t0 + 3200, lat);
    check("speed_slow", {18'd0, speed}, 32'd225);
    check("overspeed_slow", {31'd0, overspeed}, 32'd0);
    accept();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
